// File: rtl/sram_1rw_ctrl.sv
// Valid/ready access controller for a single-port 1-cycle-latency SRAM macro.
// Optional SRAM_CTRL_RD_PIPE_EN registers read data once (3-cycle latency, 3-entry FIFO).
module sram_1rw_ctrl #(
  parameter int BITS       = 15,
  parameter int WORD_DEPTH = 4096,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BITS-1:0]       req_wdata,
  input  logic [BITS-1:0]       req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BITS-1:0]       rsp_rdata,
  output logic                  rsp_err,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BITS-1:0]       sram_wd,
  output logic [BITS-1:0]       sram_wmask,
  input  logic [BITS-1:0]       sram_rd
);

`ifdef SRAM_CTRL_RD_PIPE_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 2;
`endif
  localparam int PW = (DEPTH > 2) ? 2 : 1;

  logic            fire, rd_fire, in_range;
  logic            push, pop, push_err;
  logic [BITS-1:0] push_rd;
  logic [1:0]      cnt, cnt_nxt, infl_cnt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [BITS-1:0] fifo_data [DEPTH];
  logic            fifo_err  [DEPTH];

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_range  = 32'(req_addr) < 32'(WORD_DEPTH);
  // Ready depends only on registered occupancy so rsp_ready never reaches req_ready.
  assign req_ready = rst_n & (({1'b0, cnt} + {1'b0, infl_cnt}) < 3'(DEPTH));
  assign fire      = req_valid & req_ready;
  assign rd_fire   = fire & ~req_we;

  assign sram_ce    = fire & in_range;
  assign sram_we    = fire & req_we;
  assign sram_addr  = req_addr;
  assign sram_wd    = req_wdata;
  assign sram_wmask = req_wmask;

`ifdef SRAM_CTRL_RD_PIPE_EN
  logic [1:0]      infl, err_d;
  logic [BITS-1:0] rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl  <= '0;
      err_d <= '0;
      rd_q  <= '0;
    end else begin
      infl  <= {infl[0], rd_fire};
      err_d <= {err_d[0], rd_fire & ~in_range};
      rd_q  <= sram_rd;
    end
  end

  assign push     = infl[1];
  assign push_err = err_d[1];
  assign push_rd  = rd_q;
  assign infl_cnt = {1'b0, infl[0]} + {1'b0, infl[1]};
`else
  logic infl, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl  <= 1'b0;
      err_d <= 1'b0;
    end else begin
      infl  <= rd_fire;
      err_d <= rd_fire & ~in_range;
    end
  end

  assign push     = infl;
  assign push_err = err_d;
  assign push_rd  = sram_rd;
  assign infl_cnt = {1'b0, infl};
`endif

  assign rsp_valid = (cnt != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_rdata = fifo_data[rd_ptr];
  assign rsp_err   = fifo_err[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_err[i]  <= 1'b0;
      end
    end else begin
      cnt <= cnt_nxt;
      if (push) begin
        fifo_data[wr_ptr] <= push_err ? '0 : push_rd;
        fifo_err[wr_ptr]  <= push_err;
        wr_ptr            <= nxt_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= nxt_ptr(rd_ptr);
    end
  end

endmodule

// File: tb/tb_sram_1rw_ctrl.sv
// Scoreboard bench for sram_1rw_ctrl with a behavioural SRAM macro model.
module tb_sram_1rw_ctrl;
  localparam int BITS = 15;
  localparam int WD   = 4000;
  localparam int AW   = 12;
`ifdef SRAM_CTRL_RD_PIPE_EN
  localparam int LAT = 3;
  localparam int ACC = 3;
`else
  localparam int LAT = 2;
  localparam int ACC = 2;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_ready, req_we;
  logic [AW-1:0]   req_addr;
  logic [BITS-1:0] req_wdata, req_wmask;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [BITS-1:0] rsp_rdata;
  logic            sram_ce, sram_we;
  logic [AW-1:0]   sram_addr;
  logic [BITS-1:0] sram_wd, sram_wmask;
  logic [BITS-1:0] sram_rd = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_extra  = 0;

  logic [BITS-1:0] sram_mem  [4096];
  logic [BITS-1:0] model_mem [4096];
  logic [BITS:0]   sb [$];

  always #5 clk = ~clk;

  sram_1rw_ctrl #(.BITS(BITS), .WORD_DEPTH(WD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wd(sram_wd), .sram_wmask(sram_wmask), .sram_rd(sram_rd)
  );

  // SRAM macro: masked write, registered read data.
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we)
        sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_wmask) | (sram_wd & sram_wmask);
      else
        sram_rd <= sram_mem[sram_addr];
    end
  end

  function automatic logic [BITS-1:0] init_val(input int i);
    return BITS'((i * 37) ^ 32'h2AB5);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_extra++;
        check("rsp_extra", n_extra, 0);
      end else begin
        logic [BITS:0] e;
        e = sb.pop_front();
        check("rsp", {rsp_err, rsp_rdata}, e);
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the fire edge.
  task automatic issue(input logic we, input int addr, input logic [BITS-1:0] wd,
                       input logic [BITS-1:0] mask);
    logic ok;
    req_valid = 1'b1; req_we = we; req_addr = AW'(addr);
    req_wdata = wd;   req_wmask = mask;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    check("req_accept", ok, 1);
    if (ok) begin
      check("sram_ce", sram_ce, addr < WD);
      check("sram_we", sram_we, we);
      check("sram_addr", sram_addr, addr);
      if (we) begin
        if (addr < WD) model_mem[addr] = (model_mem[addr] & ~mask) | (wd & mask);
      end else begin
        sb.push_back((addr < WD) ? {1'b0, model_mem[addr]} : {1'b1, {BITS{1'b0}}});
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic read_lat(input int addr, input logic [BITS-1:0] exp_d, input logic exp_e);
    issue(1'b0, addr, '0, '0);
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      check("lat_early", rsp_valid, 0);
    end
    @(negedge clk);
    check("lat_valid", rsp_valid, 1);
    check("lat_rdata", rsp_rdata, exp_d);
    check("lat_err", rsp_err, exp_e);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sram_mem[i]  = init_val(i);
      model_mem[i] = init_val(i);
    end
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(5);
    req_wdata = '0; req_wmask = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_sram_ce", sram_ce, 0);
    check("rst_sram_we", sram_we, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(posedge clk); #1;
    req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    @(posedge clk); #1;

    issue(1'b1, 'h123, 15'h5A5A, 15'h7FFF);
    read_lat('h123, 15'h5A5A, 1'b0);

    issue(1'b1, 'h200, 15'h7FFF, 15'h7FFF);
    issue(1'b1, 'h200, 15'h0000, 15'h00FF);
    read_lat('h200, 15'h7F00, 1'b0);

    read_lat(4000, '0, 1'b1);
    issue(1'b1, 4095, 15'h1234, '1);
    read_lat(4095, '0, 1'b1);
    read_lat(3999, init_val(3999), 1'b0);

    for (int i = 0; i < 16; i++)
      issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
            BITS'($urandom), BITS'($urandom));
    drain();

    rsp_ready = 1'b0;
    for (int a = 1; a <= ACC; a++) issue(1'b0, a, '0, '0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(ACC + 1);
    repeat (3) begin
      @(negedge clk);
      check("bp_ready", req_ready, 0);
    end
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_head", rsp_rdata, init_val(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int a = ACC + 1; a <= 4; a++) issue(1'b0, a, '0, '0);
    drain();

    rsp_ready = 1'b0;
    issue(1'b0, 10, '0, '0);
    issue(1'b0, 11, '0, '0);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_req_ready", req_ready, 0);
    sb.delete();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("stale_rsp", rsp_valid, 0);
    end
    check("rsp_extra_total", n_extra, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
